reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Shares the single register-file write port among NUM_REQ writeback requesters
//  (e.g. ALU writeback, load unit, multi-cycle multiply) using round-robin arbitration.
//  Sits between the writeback sources and clocked_reg_file (write_en_i/write_addr_i/reg_data_i).
//  Also provides a pending-write query so decode can stall on registers not yet written.
// PARAMETERS
//  NUM_REQ     2   number of writeback requesters (>=2)
//  ADDR_WIDTH  4   register address width
//  DATA_WIDTH  32  register data width
//  NUM_CHK     3   number of pending-write query ports (one per read port)
// PORTS
//  clk_i          in   1                    clock; all state updates on posedge
//  rst_i          in   1                    synchronous reset, active high
//  req_valid_i    in   NUM_REQ              requester i has a write to perform
//  req_addr_i     in   NUM_REQ*ADDR_WIDTH   dest register of requester i (slice i)
//  req_data_i     in   NUM_REQ*DATA_WIDTH   write data of requester i (slice i)
//  req_ready_o    out  NUM_REQ              one-hot grant; transfer when valid&ready
//  write_en_o     out  1                    to register file write_en_i
//  write_addr_o   out  ADDR_WIDTH           to register file write_addr_i
//  write_data_o   out  DATA_WIDTH           to register file reg_data_i
//  chk_addr_i     in   NUM_CHK*ADDR_WIDTH   register addresses being read by decode
//  chk_pending_o  out  NUM_CHK              1 = a write to that address is in flight
//  busy_o         out  1                    any req_valid_i high or write_en_o high
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): write_en_o=0, write_addr_o=0, write_data_o=0, rr pointer=0.
//    While rst_i=1, req_ready_o=0 (combinational). Requests present during reset are not
//    transferred; requesters keep valid and are served after reset deasserts.
//  - Handshake: requester holds valid/addr/data stable until it sees ready. req_ready_o
//    depends combinationally on req_valid_i; at most one bit is set per cycle; never set
//    for a requester whose valid is 0.
//  - Arbitration: grant = first valid index searching ptr, ptr+1, ... wrapping mod NUM_REQ.
//    Idle requesters are skipped (no empty cycles). After a grant to index g,
//    ptr <= (g+1) mod NUM_REQ; with no grant, ptr holds.
//  - Fairness: a continuously valid requester is granted within NUM_REQ cycles.
//  - Output stage: registered, latency 1. Cycle t grant -> at posedge t+1
//    write_en_o=1, write_addr_o/write_data_o = granted slice. No grant -> write_en_o=0;
//    addr/data hold their last value. Back-to-back grants give back-to-back writes.
//  - Throughput: one write per cycle maximum; no internal buffering beyond output register.
//  - Pending query (combinational): chk_pending_o[k]=1 iff chk_addr_k equals req_addr of
//    any requester with req_valid_i=1 (granted this cycle or not), or write_en_o=1 and
//    write_addr_o==chk_addr_k. Cleared once the write has left the output register.
//    During rst_i=1 only the requester term applies (output stage term forced 0).
//  - Same address from several requesters: served in grant order, one per cycle; register
//    ends with the last granted value. Cross-requester program order is the requesters'
//    responsibility; this block does not reorder or merge.
//  - Widths: req slice i occupies bits [i*W +: W]. ptr is $clog2(NUM_REQ) bits; wrap at
//    NUM_REQ-1 -> 0 for non-power-of-two NUM_REQ.
// TESTING
//  1. Only req0 valid, addr 3, data 32'hDEADBEEF -> req_ready_o=2'b01 same cycle; next
//     cycle write_en_o=1, addr 3, data DEADBEEF; cycle after write_en_o=0.
//  2. req0 and req1 both held valid 6 cycles, ptr=0 -> grants 0,1,0,1,0,1; write_en_o=1
//     on every cycle from cycle 1 to 6.
//  3. req0 addr 2, req1 addr 5 valid, chk_addr_0=5 -> chk_pending_o[0]=1 on cycles 0,1
//     (waiting), cycle 2 (output stage), 0 on cycle 3.
//  4. rst_i=1 while both valid -> req_ready_o=0, next cycle write_en_o=0 and ptr=0;
//     after deassert req0 is granted first.
//  5. NUM_REQ=3, req0 and req2 valid, req1 idle -> grants alternate 0,2,0,2 with no gaps.
//  6. req0 and req1 both target addr 7 (data 1 and 2), ptr=1 -> write 7<=2 then 7<=1;
//     chk_pending for addr 7 stays 1 until the second write leaves the output stage.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Writeback request / register-file write / pending-query bundle for reg_write_arbiter.
// master = writeback sources and decode; slave = the arbiter.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CHK    = 3
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          write_en_o;
    logic [ADDR_WIDTH-1:0]         write_addr_o;
    logic [DATA_WIDTH-1:0]         write_data_o;
    logic [NUM_CHK*ADDR_WIDTH-1:0] chk_addr_i;
    logic [NUM_CHK-1:0]            chk_pending_o;
    logic                          busy_o;

    modport master (
        output req_valid_i, req_addr_i, req_data_i, chk_addr_i,
        input  req_ready_o, write_en_o, write_addr_o, write_data_o, chk_pending_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, chk_addr_i,
        output req_ready_o, write_en_o, write_addr_o, write_data_o, chk_pending_o, busy_o
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback
// sources, with a registered write stage and a combinational pending-write query.
module reg_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CHK    = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    reg_write_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      scan_idx;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_vld;
    logic [NUM_REQ-1:0]    ready;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_addr[i] = bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_data[i] = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan ptr, ptr+1, ... modulo NUM_REQ; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && !rst_i && bus.req_valid_i[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (grant_vld) begin
            ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ptr_q     <= '0;
        end else begin
            wr_en_q <= grant_vld;
            if (grant_vld) begin
                wr_addr_q <= req_addr[grant_idx];
                wr_data_q <= req_data[grant_idx];
                ptr_q     <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // A register is pending while any valid requester targets it or it sits in the output stage.
    for (genvar k = 0; k < NUM_CHK; k++) begin : g_chk
        logic [ADDR_WIDTH-1:0] chk_a;
        logic [NUM_REQ-1:0]    hit;
        assign chk_a = bus.chk_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            assign hit[i] = bus.req_valid_i[i] && (req_addr[i] == chk_a);
        end
        assign bus.chk_pending_o[k] = (|hit) || (wr_en_q && !rst_i && (wr_addr_q == chk_a));
    end

    assign bus.req_ready_o  = ready;
    assign bus.write_en_o   = wr_en_q;
    assign bus.write_addr_o = wr_addr_q;
    assign bus.write_data_o = wr_data_q;
    assign bus.busy_o       = (|bus.req_valid_i) || wr_en_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model.
module tb_reg_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model of the 2-requester instance
    int          m_ptr  = 0;
    logic        m_we   = 1'b0;
    logic [3:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          last_g = -1;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_CHK(3)) bus2 ();
    reg_write_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_CHK(3)) bus3 ();

    reg_write_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_CHK(3)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(bus2.slave));
    reg_write_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_CHK(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .bus(bus3.slave));

    function automatic int exp_grant(input logic [7:0] v, input int ptr, input int n, input logic r);
        if (r) return -1;
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    // Advance the model from the currently driven bus2 inputs, then cross one posedge.
    task automatic step();
        int g;
        g = exp_grant({6'b0, bus2.req_valid_i}, m_ptr, 2, rst);
        if (rst) begin
            m_we = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
        end else begin
            m_we = (g >= 0);
            if (g >= 0) begin
                m_addr = bus2.req_addr_i[g*4 +: 4];
                m_data = bus2.req_data_i[g*32 +: 32];
                m_ptr  = (g + 1) % 2;
            end
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus2.req_valid_i = 2'b10;
        bus2.req_addr_i  = {4'd9, 4'd1};
        bus2.req_data_i  = {32'h99, 32'h11};
        bus2.chk_addr_i  = {4'd4, 4'd9, 4'd1};
        #1;
        step();
        bus2.req_valid_i = 2'b00;
        #1;
        n_checks++;
        if ({bus2.write_en_o, bus2.write_addr_o, bus2.chk_pending_o} !== {1'b1, 4'd9, 3'b010}) begin
            n_fail++;
            $display("FAIL reset_prewrite: got we/addr/pend=%b/%0d/%b want 1/9/010",
                     bus2.write_en_o, bus2.write_addr_o, bus2.chk_pending_o);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus2.chk_pending_o !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pend_outstage: got %b want 000", bus2.chk_pending_o);
        end
        bus2.req_valid_i = 2'b11;
        #1;
        n_checks++;
        if ({bus2.req_ready_o, bus2.chk_pending_o, bus2.busy_o} !== {2'b00, 3'b011, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_ready: got ready/pend/busy=%b/%b/%b want 00/011/1",
                     bus2.req_ready_o, bus2.chk_pending_o, bus2.busy_o);
        end
        step();
        n_checks++;
        if ({bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o} !== {1'b0, 4'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got we/addr/data=%b/%0d/%h want 0/0/0",
                     bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus2.req_ready_o !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want 01", bus2.req_ready_o);
        end
        step();
        bus2.req_valid_i = 2'b10;
        #1;
        n_checks++;
        if ({bus2.req_ready_o, bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o}
            !== {2'b10, 1'b1, 4'd1, 32'h11}) begin
            n_fail++;
            $display("FAIL reset_after1: got ready/we/addr/data=%b/%b/%0d/%h want 10/1/1/11",
                     bus2.req_ready_o, bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o);
        end
        step();
        bus2.req_valid_i = 2'b00;
        #1;
        n_checks++;
        if ({bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o} !== {1'b1, 4'd9, 32'h99}) begin
            n_fail++;
            $display("FAIL reset_after2: got we/addr/data=%b/%0d/%h want 1/9/99",
                     bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o);
        end
        step();
        n_checks++;
        if (bus2.write_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got we=%b want 0", bus2.write_en_o);
        end
    endtask

    task automatic test_single();
        bus2.req_valid_i = 2'b01;
        bus2.req_addr_i  = {4'd0, 4'd3};
        bus2.req_data_i  = {32'h0, 32'hDEADBEEF};
        #1;
        n_checks++;
        if (bus2.req_ready_o !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 01", bus2.req_ready_o);
        end
        step();
        bus2.req_valid_i = 2'b00;
        #1;
        n_checks++;
        if ({bus2.req_ready_o, bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o}
            !== {2'b00, 1'b1, 4'd3, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL single_write: got ready/we/addr/data=%b/%b/%0d/%h want 00/1/3/deadbeef",
                     bus2.req_ready_o, bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o);
        end
        step();
        n_checks++;
        if ({bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o} !== {1'b0, 4'd3, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL single_hold: got we/addr/data=%b/%0d/%h want 0/3/deadbeef",
                     bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [2];
        logic [3:0]  prev_a;
        logic [31:0] prev_d;
        // a lone req1 grant brings the pointer back to 0
        bus2.req_valid_i = 2'b10;
        step();
        bus2.req_valid_i = 2'b00;
        step();
        d[0] = 32'd100;
        d[1] = 32'd200;
        prev_a = '0;
        prev_d = '0;
        bus2.req_addr_i  = {4'hB, 4'hA};
        bus2.req_valid_i = 2'b11;
        for (int c = 0; c < 6; c++) begin
            bus2.req_data_i = {d[1], d[0]};
            #1;
            n_checks++;
            if (bus2.req_ready_o !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: got %b want %b", c, bus2.req_ready_o,
                         (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (c > 0) begin
                n_checks++;
                if ({bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o} !== {1'b1, prev_a, prev_d}) begin
                    n_fail++;
                    $display("FAIL b2b_write[%0d]: got we/addr/data=%b/%h/%0d want 1/%h/%0d", c,
                             bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o, prev_a, prev_d);
                end
            end
            prev_a = (c % 2 == 0) ? 4'hA : 4'hB;
            prev_d = d[c % 2];
            step();
            d[c % 2] = d[c % 2] + 1;
        end
        bus2.req_valid_i = 2'b00;
        #1;
        n_checks++;
        if ({bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o} !== {1'b1, prev_a, prev_d}) begin
            n_fail++;
            $display("FAIL b2b_last: got we/addr/data=%b/%h/%0d want 1/%h/%0d",
                     bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o, prev_a, prev_d);
        end
        step();
        n_checks++;
        if (bus2.write_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got we=%b want 0", bus2.write_en_o);
        end
    endtask

    task automatic test_pending();
        bus2.req_valid_i = 2'b11;
        bus2.req_addr_i  = {4'd5, 4'd2};
        bus2.chk_addr_i  = {4'd0, 4'd0, 4'd5};
        #1;
        n_checks++;
        if ({bus2.chk_pending_o[0], bus2.req_ready_o} !== {1'b1, 2'b01}) begin
            n_fail++;
            $display("FAIL pend_c0: got pend/ready=%b/%b want 1/01", bus2.chk_pending_o[0], bus2.req_ready_o);
        end
        step();
        bus2.req_valid_i = 2'b10;
        #1;
        n_checks++;
        if ({bus2.chk_pending_o[0], bus2.req_ready_o} !== {1'b1, 2'b10}) begin
            n_fail++;
            $display("FAIL pend_c1: got pend/ready=%b/%b want 1/10", bus2.chk_pending_o[0], bus2.req_ready_o);
        end
        step();
        bus2.req_valid_i = 2'b00;
        #1;
        n_checks++;
        if ({bus2.chk_pending_o[0], bus2.write_en_o, bus2.write_addr_o} !== {1'b1, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL pend_c2: got pend/we/addr=%b/%b/%0d want 1/1/5",
                     bus2.chk_pending_o[0], bus2.write_en_o, bus2.write_addr_o);
        end
        step();
        n_checks++;
        if (bus2.chk_pending_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_c3: got %b want 0", bus2.chk_pending_o[0]);
        end
    endtask

    task automatic test_same_addr();
        // a lone req0 grant leaves the pointer at 1
        bus2.req_valid_i = 2'b01;
        bus2.req_addr_i  = {4'd0, 4'd0};
        step();
        bus2.req_valid_i = 2'b00;
        step();
        bus2.req_addr_i  = {4'd7, 4'd7};
        bus2.req_data_i  = {32'd2, 32'd1};
        bus2.chk_addr_i  = {4'd0, 4'd0, 4'd7};
        bus2.req_valid_i = 2'b11;
        #1;
        n_checks++;
        if ({bus2.req_ready_o, bus2.chk_pending_o[0]} !== {2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL same_c0: got ready/pend=%b/%b want 10/1", bus2.req_ready_o, bus2.chk_pending_o[0]);
        end
        step();
        bus2.req_valid_i = 2'b01;
        #1;
        n_checks++;
        if ({bus2.req_ready_o, bus2.chk_pending_o[0], bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o}
            !== {2'b01, 1'b1, 1'b1, 4'd7, 32'd2}) begin
            n_fail++;
            $display("FAIL same_c1: got ready/pend/we/addr/data=%b/%b/%b/%0d/%0d want 01/1/1/7/2",
                     bus2.req_ready_o, bus2.chk_pending_o[0], bus2.write_en_o, bus2.write_addr_o,
                     bus2.write_data_o);
        end
        step();
        bus2.req_valid_i = 2'b00;
        #1;
        n_checks++;
        if ({bus2.chk_pending_o[0], bus2.write_en_o, bus2.write_data_o} !== {1'b1, 1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL same_c2: got pend/we/data=%b/%b/%0d want 1/1/1",
                     bus2.chk_pending_o[0], bus2.write_en_o, bus2.write_data_o);
        end
        step();
        n_checks++;
        if ({bus2.chk_pending_o[0], bus2.write_en_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL same_c3: got pend/we=%b/%b want 0/0", bus2.chk_pending_o[0], bus2.write_en_o);
        end
    endtask

    task automatic test_three_skip();
        logic [2:0] want;
        bus3.req_valid_i = 3'b101;
        bus3.req_addr_i  = {4'd2, 4'd0, 4'd1};
        bus3.req_data_i  = {32'h22, 32'h0, 32'h11};
        for (int c = 0; c < 4; c++) begin
            #1;
            want = (c % 2 == 0) ? 3'b001 : 3'b100;
            n_checks++;
            if (bus3.req_ready_o !== want) begin
                n_fail++;
                $display("FAIL three_grant[%0d]: got %b want %b", c, bus3.req_ready_o, want);
            end
            if (c > 0) begin
                n_checks++;
                if ({bus3.write_en_o, bus3.write_addr_o} !== {1'b1, (c % 2 == 1) ? 4'd1 : 4'd2}) begin
                    n_fail++;
                    $display("FAIL three_write[%0d]: got we/addr=%b/%0d want 1/%0d", c,
                             bus3.write_en_o, bus3.write_addr_o, (c % 2 == 1) ? 1 : 2);
                end
            end
            step();
        end
        bus3.req_valid_i = 3'b000;
        #1;
        n_checks++;
        if ({bus3.write_en_o, bus3.write_addr_o, bus3.write_data_o} !== {1'b1, 4'd2, 32'h22}) begin
            n_fail++;
            $display("FAIL three_last: got we/addr/data=%b/%0d/%h want 1/2/22",
                     bus3.write_en_o, bus3.write_addr_o, bus3.write_data_o);
        end
        step();
    endtask

    task automatic test_random();
        logic [1:0]  rv;
        logic [3:0]  ra [2];
        logic [31:0] rd [2];
        logic [3:0]  ck [3];
        logic [1:0]  e_ready;
        logic [2:0]  e_pend;
        logic        e_busy;
        int          g;
        rv = '0;
        ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] && $urandom_range(0, 2) != 0) begin
                    rv[i] = 1'b1;
                    ra[i] = 4'($urandom_range(0, 3));
                    rd[i] = $urandom;
                end
            end
            for (int k = 0; k < 3; k++) ck[k] = 4'($urandom_range(0, 3));
            bus2.req_valid_i = rv;
            bus2.req_addr_i  = {ra[1], ra[0]};
            bus2.req_data_i  = {rd[1], rd[0]};
            bus2.chk_addr_i  = {ck[2], ck[1], ck[0]};
            #1;
            g = exp_grant({6'b0, rv}, m_ptr, 2, rst);
            e_ready = (g >= 0) ? 2'(1 << g) : 2'b00;
            for (int k = 0; k < 3; k++) begin
                e_pend[k] = m_we && !rst && (m_addr == ck[k]);
                for (int i = 0; i < 2; i++) begin
                    if (rv[i] && ra[i] == ck[k]) e_pend[k] = 1'b1;
                end
            end
            e_busy = (|rv) || m_we;
            n_checks++;
            if ({bus2.req_ready_o, bus2.chk_pending_o, bus2.busy_o} !== {e_ready, e_pend, e_busy}) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: got ready/pend/busy=%b/%b/%b want %b/%b/%b", c,
                         bus2.req_ready_o, bus2.chk_pending_o, bus2.busy_o, e_ready, e_pend, e_busy);
            end
            n_checks++;
            if ({bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o} !== {m_we, m_addr, m_data}) begin
                n_fail++;
                $display("FAIL rand_write[%0d]: got we/addr/data=%b/%0d/%h want %b/%0d/%h", c,
                         bus2.write_en_o, bus2.write_addr_o, bus2.write_data_o, m_we, m_addr, m_data);
            end
            step();
            if (last_g >= 0) rv[last_g] = 1'b0;
        end
        rst = 1'b0;
        bus2.req_valid_i = 2'b00;
        step();
    endtask

    initial begin
        bus2.req_valid_i = '0; bus2.req_addr_i = '0; bus2.req_data_i = '0; bus2.chk_addr_i = '0;
        bus3.req_valid_i = '0; bus3.req_addr_i = '0; bus3.req_data_i = '0; bus3.chk_addr_i = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        test_reset();
        test_single();
        test_back_to_back();
        test_pending();
        test_same_addr();
        test_three_skip();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
